// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiplier or quotient bit per cycle; MTHI/MTLO and divide-by-zero finish in one cycle.
module muldiv_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [5:0]       op_i,
   input  logic [WIDTH-1:0] regaData,
   input  logic [WIDTH-1:0] regbData,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [5:0] OpMthi  = 6'h11;
   localparam logic [5:0] OpMtlo  = 6'h13;
   localparam logic [5:0] OpMult  = 6'h18;
   localparam logic [5:0] OpMultu = 6'h19;
   localparam logic [5:0] OpDiv   = 6'h1a;
   localparam logic [5:0] OpDivu  = 6'h1b;

   typedef enum logic {StIdle, StRun} state_e;

   state_e                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [2*WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]       r_opb;
   logic                   r_is_div;
   logic                   r_neg_q;
   logic                   r_neg_r;
   logic                   r_done;
   logic                   r_dz;
   logic [WIDTH-1:0]       r_hi;
   logic [WIDTH-1:0]       r_lo;

   logic                   w_op_div;
   logic                   w_signed;
   logic                   w_a_neg;
   logic                   w_b_neg;
   logic [WIDTH-1:0]       w_a_abs;
   logic [WIDTH-1:0]       w_b_abs;
   logic [WIDTH:0]         w_sum;
   logic [WIDTH:0]         w_trial;
   logic [2*WIDTH-1:0]     w_acc_next;
   logic [2*WIDTH-1:0]     w_prod;
   logic [WIDTH-1:0]       w_quo;
   logic [WIDTH-1:0]       w_rem;
   logic [WIDTH-1:0]       w_wb_hi;
   logic [WIDTH-1:0]       w_wb_lo;

   always_comb begin
      w_op_div = (op_i == OpDiv) || (op_i == OpDivu);
      w_signed = (op_i == OpMult) || (op_i == OpDiv);
      w_a_neg  = w_signed & regaData[WIDTH-1];
      w_b_neg  = w_signed & regbData[WIDTH-1];
      w_a_abs  = w_a_neg ? (~regaData + 1'b1) : regaData;
      w_b_abs  = w_b_neg ? (~regbData + 1'b1) : regbData;
   end

   // Multiply: accumulator holds {partial product, remaining multiplier bits}.
   // Divide: accumulator holds {partial remainder, dividend/quotient bits}.
   always_comb begin
      w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
      w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
      if (r_is_div) begin
         if (!w_trial[WIDTH]) begin
            w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      w_prod  = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
      w_quo   = r_neg_q ? (~w_acc_next[WIDTH-1:0] + 1'b1) : w_acc_next[WIDTH-1:0];
      w_rem   = r_neg_r ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                        : w_acc_next[2*WIDTH-1:WIDTH];
      w_wb_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
      w_wb_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
         r_dz     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         if (r_state == StIdle) begin
            if (start_i && !flush_i) begin
               case (op_i)
                  OpMthi: begin
                     r_hi   <= regaData;
                     r_done <= 1'b1;
                  end
                  OpMtlo: begin
                     r_lo   <= regaData;
                     r_done <= 1'b1;
                  end
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     if (w_op_div && (regbData == '0)) begin
                        r_hi   <= regaData;
                        r_lo   <= '1;
                        r_done <= 1'b1;
                        r_dz   <= 1'b1;
                     end else begin
                        r_acc    <= w_op_div ? {{WIDTH{1'b0}}, w_a_abs}
                                             : {{WIDTH{1'b0}}, w_b_abs};
                        r_opb    <= w_op_div ? w_b_abs : w_a_abs;
                        r_is_div <= w_op_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_cnt    <= CW'(WIDTH);
                        r_state  <= StRun;
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            if (flush_i) begin
               r_state <= StIdle;
               r_cnt   <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_hi    <= w_wb_hi;
                  r_lo    <= w_wb_lo;
                  r_done  <= 1'b1;
                  r_state <= StIdle;
               end
            end
         end
      end
   end

   assign busy_o     = (r_state == StRun);
   assign done_o     = r_done;
   assign div_zero_o = r_dz;
   assign hi_o       = r_hi;
   assign lo_o       = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo with a transaction-level reference model
// checked every cycle, plus literal expectations for each directed case.
module tb_muldiv_hilo;

   localparam logic [5:0] OpMthi  = 6'h11;
   localparam logic [5:0] OpMtlo  = 6'h13;
   localparam logic [5:0] OpMult  = 6'h18;
   localparam logic [5:0] OpMultu = 6'h19;
   localparam logic [5:0] OpDiv   = 6'h1a;
   localparam logic [5:0] OpDivu  = 6'h1b;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [5:0]  op_i;
   logic [31:0] rega;
   logic [31:0] regb;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic        div_zero_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks = 0;
   int errors = 0;

   muldiv_hilo #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .regaData   (rega),
      .regbData   (regb),
      .flush_i    (flush_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .div_zero_o (div_zero_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: result computed with plain 64-bit arithmetic, released after 32 cycles.
   logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
   int          m_left = 0;

   initial begin
      longint x, y, r;
      logic [63:0] p;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
         end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
               if (flush_i) m_left = 0;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_hi = m_pend_hi; m_lo = m_pend_lo; m_done = 1'b1;
                  end
               end
            end else if (start_i && !flush_i) begin
               if (op_i == OpMult || op_i == OpDiv) begin
                  x = longint'($signed(rega)); y = longint'($signed(regb));
               end else begin
                  x = longint'({32'd0, rega}); y = longint'({32'd0, regb});
               end
               case (op_i)
                  OpMthi: begin m_hi = rega; m_done = 1'b1; end
                  OpMtlo: begin m_lo = rega; m_done = 1'b1; end
                  OpMult, OpMultu: begin
                     p = 64'(x * y);
                     m_pend_hi = p[63:32]; m_pend_lo = p[31:0]; m_left = 32;
                  end
                  OpDiv, OpDivu: begin
                     if (regb == 32'd0) begin
                        m_hi = rega; m_lo = '1; m_done = 1'b1; m_dz = 1'b1;
                     end else begin
                        p = 64'(x / y);
                        r = x % y;
                        m_pend_lo = p[31:0]; m_pend_hi = r[31:0]; m_left = 32;
                     end
                  end
                  default: ;
               endcase
            end
            m_busy = (m_left > 0);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cyc_busy", {31'd0, busy_o}, {31'd0, m_busy});
         chk("cyc_done", {31'd0, done_o}, {31'd0, m_done});
         chk("cyc_dz", {31'd0, div_zero_o}, {31'd0, m_dz});
         chk("cyc_hi", hi_o, m_hi);
         chk("cyc_lo", lo_o, m_lo);
      end
   end

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      start_i = 1'b1; op_i = op; rega = a; regb = b;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = 0; bc = 0;
      while (!done_o && lat < 40) begin
         if (busy_o) bc++;
         @(negedge clk);
         lat++;
      end
      if (!done_o) begin
         errors++; checks++;
         $display("FAIL done_timeout actual=0 required=1 at %0t", $time);
      end
   endtask

   task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int lat, bc;
      issue(op, a, b);
      wait_done(lat, bc);
      chk({nm, "_lat"}, lat, 32);
      chk({nm, "_busycyc"}, bc, 32);
      chk({nm, "_hi"}, hi_o, ehi);
      chk({nm, "_lo"}, lo_o, elo);
      chk({nm, "_dz"}, {31'd0, div_zero_o}, 32'd0);
   endtask

   initial begin
      int lat, bc, nd;
      rst = 1'b1; start_i = 1'b0; op_i = '0; rega = '0; regb = '0; flush_i = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Async reset mid-run
      issue(OpMtlo, 32'h0000beef, 32'd0);
      chk("mtlo_lo", lo_o, 32'h0000beef);
      @(negedge clk);
      issue(OpMultu, 32'd5, 32'd6);
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy_o}, 32'd0);
      chk("arst_done", {31'd0, done_o}, 32'd0);
      chk("arst_dz", {31'd0, div_zero_o}, 32'd0);
      chk("arst_hi", hi_o, 32'd0);
      chk("arst_lo", lo_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // MTHI: one-cycle, no busy
      issue(OpMthi, 32'h12345678, 32'd0);
      chk("mthi_done", {31'd0, done_o}, 32'd1);
      chk("mthi_busy", {31'd0, busy_o}, 32'd0);
      chk("mthi_hi", hi_o, 32'h12345678);
      @(negedge clk);
      chk("mthi_done_pulse", {31'd0, done_o}, 32'd0);

      run_op("mult", OpMult, 32'hfffffffe, 32'd3, 32'hffffffff, 32'hfffffffa);
      @(negedge clk);
      run_op("multu", OpMultu, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001);
      // Issued in the done cycle: back-to-back
      run_op("divu", OpDivu, 32'd7, 32'd2, 32'd1, 32'd3);
      run_op("div_n7_2", OpDiv, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd);
      run_op("div_7_n2", OpDiv, 32'd7, 32'hfffffffe, 32'h00000001, 32'hfffffffd);
      run_op("div_min", OpDiv, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000);

      // Divide by zero
      issue(OpDivu, 32'd5, 32'd0);
      wait_done(lat, bc);
      chk("dz_lat", lat, 32'd0);
      chk("dz_done", {31'd0, done_o}, 32'd1);
      chk("dz_flag", {31'd0, div_zero_o}, 32'd1);
      chk("dz_busy", {31'd0, busy_o}, 32'd0);
      chk("dz_hi", hi_o, 32'd5);
      chk("dz_lo", lo_o, 32'hffffffff);
      @(negedge clk);

      // Ignored start at iteration 5, flush at iteration 10
      issue(OpMult, 32'd7, 32'd9);
      repeat (4) @(negedge clk);
      start_i = 1'b1; op_i = OpDiv; rega = 32'd100; regb = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      chk("ign_busy", {31'd0, busy_o}, 32'd1);
      repeat (4) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_busy", {31'd0, busy_o}, 32'd0);
      chk("flush_hi", hi_o, 32'd5);
      chk("flush_lo", lo_o, 32'hffffffff);
      nd = 0;
      for (int i = 0; i < 35; i++) begin
         if (done_o) nd++;
         @(negedge clk);
      end
      chk("flush_nodone", nd, 32'd0);
      run_op("multu_3x4", OpMultu, 32'd3, 32'd4, 32'd0, 32'd12);
      @(negedge clk);

      // Flush coinciding with the final iteration
      issue(OpMult, 32'd2, 32'd3);
      repeat (31) @(negedge clk);
      chk("last_busy", {31'd0, busy_o}, 32'd1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("lastfl_done", {31'd0, done_o}, 32'd0);
      chk("lastfl_busy", {31'd0, busy_o}, 32'd0);
      chk("lastfl_lo", lo_o, 32'd12);

      // Flush beats start in idle
      start_i = 1'b1; flush_i = 1'b1; op_i = OpMthi; rega = 32'haaaa5555;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      chk("idlefl_done", {31'd0, done_o}, 32'd0);
      chk("idlefl_hi", hi_o, 32'd0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
